// File: rtl/mouse_ps2_controller.sv
// PS/2 mouse sequencer with a memory-mapped packet/status register file.
//
// mouse_ps2_regs
//    Register file and address decode. It holds the packet register, the
//    sequence counter and the valid/overrun flags. It also decodes the
//    restart command.
//    clk_sys, rst_b     : clock, async active-low reset
//    rd_en, wr_en       : bus strobes
//    byte_en, addr      : bus byte enables and address
//    wr_data            : bus write data
//    pkt_done           : a packet completed this cycle
//    pkt_bytes          : {b2, b1, b0} of the completed packet
//    fail, ready        : FSM status bits mirrored in the status register
//    restart            : restart command decoded this cycle
//    valid              : packet-valid flag
//    rd_hit, rd_val     : address matched / selected read value
//
// mouse_ps2_controller (top)
//    Init/stream sequencer in front of the PS/2 byte transceiver.
//    iCLK, Reset_n                 : clock, async active-low reset
//    rx_data, rx_valid             : received byte
//    tx_data, tx_req               : command byte and its request (held)
//    tx_done, tx_err               : transmit outcome pulses
//    wReadEnable .. wWriteData     : processor IO bus
//    wReadData                     : read data, Z when not addressed
//    oIRQ                          : level interrupt (packet valid)
//    oReady                        : high in the stream states

module mouse_ps2_regs #(
   parameter logic [31:0] BUFFER_ADDR = 32'hFF200110,
   parameter logic [31:0] STATUS_ADDR = 32'hFF200114
) (
   input  logic        clk_sys,
   input  logic        rst_b,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [3:0]  byte_en,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic        pkt_done,
   input  logic [23:0] pkt_bytes,
   input  logic        fail,
   input  logic        ready,
   output logic        restart,
   output logic        valid,
   output logic        rd_hit,
   output logic [31:0] rd_val
);
   logic [31:0] pkt_q, pkt_d;
   logic [7:0]  seq_q, seq_d;
   logic        valid_q, valid_d;
   logic        overrun_q, overrun_d;
   logic        buf_sel, stat_sel, buf_rd, stat_rd;
   logic        unused_wr_bits;

   assign buf_sel  = (addr == BUFFER_ADDR);
   assign stat_sel = (addr == STATUS_ADDR);
   assign buf_rd   = rd_en & buf_sel;
   assign stat_rd  = rd_en & stat_sel;
   assign restart  = wr_en & stat_sel & byte_en[0] & wr_data[0];
   assign unused_wr_bits = ^{byte_en[3:1], wr_data[31:1]};

   always_comb begin
      pkt_d     = pkt_q;
      seq_d     = seq_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (buf_rd)
         valid_d = 1'b0;
      if (stat_rd)
         overrun_d = 1'b0;
      // A completing packet beats a clearing read on the same edge.
      if (pkt_done) begin
         seq_d   = seq_q + 8'd1;
         pkt_d   = {seq_q + 8'd1, pkt_bytes};
         valid_d = 1'b1;
         if (valid_q && !buf_rd)
            overrun_d = 1'b1;
      end
      if (restart) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         pkt_q     <= '0;
         seq_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         pkt_q     <= pkt_d;
         seq_q     <= seq_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      rd_hit = buf_sel | stat_sel;
      rd_val = pkt_q;
      if (stat_sel)
         rd_val = {28'b0, overrun_q, fail, ready, valid_q};
   end

   assign valid = valid_q;
endmodule

// state     | meaning
// RST_SEND  | request transmission of reset command 0xFF
// RST_ACK   | wait for 0xFA acknowledging reset
// RST_BAT   | wait for 0xAA self-test passed
// RST_ID    | wait for 0x00 device id
// EN_SEND   | request transmission of enable-streaming 0xF4
// EN_ACK    | wait for 0xFA acknowledging enable
// STREAM_B0 | wait for packet byte 0 (bit3 set)
// STREAM_B1 | wait for packet byte 1 (timed)
// STREAM_B2 | wait for packet byte 2 (timed)
// FAIL      | retries exhausted, idle until restart
module mouse_ps2_controller #(
   parameter logic [31:0] BUFFER_ADDR    = 32'hFF200110,
   parameter logic [31:0] STATUS_ADDR    = 32'hFF200114,
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter int          MAX_RETRY      = 3
) (
   input  logic        iCLK,
   input  logic        Reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_req,
   input  logic        tx_done,
   input  logic        tx_err,
   input  logic        wReadEnable,
   input  logic        wWriteEnable,
   input  logic [3:0]  wByteEnable,
   input  logic [31:0] wAddress,
   input  logic [31:0] wWriteData,
   output logic [31:0] wReadData,
   output logic        oIRQ,
   output logic        oReady
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CYCLES);
   localparam logic [RW:0]   RETRY_LIM = (RW + 1)'(MAX_RETRY);

   typedef enum logic [3:0] {
      ST_RST_SEND, ST_RST_ACK, ST_RST_BAT, ST_RST_ID, ST_EN_SEND,
      ST_EN_ACK, ST_STREAM_B0, ST_STREAM_B1, ST_STREAM_B2, ST_FAIL
   } state_t;

   state_t        state_q, state_d, fail_tgt;
   logic          tx_req_q, tx_req_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [RW:0]   retry_inc;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          tmr_done;
   logic [7:0]    b0_q, b0_d, b1_q, b1_d;
   logic          fail_q, fail_d;
   logic          ready_q, ready_d;
   logic          failure, pkt_done, pkt_done_ok;
   logic          restart, valid, rd_hit;
   logic [31:0]   rd_val;

   assign tmr_done  = (tmr_q == '0);
   assign retry_inc = {1'b0, retry_q} + (RW + 1)'(1);

   always_comb begin
      state_d   = state_q;
      tx_req_d  = tx_req_q;
      tx_data_d = tx_data_q;
      retry_d   = retry_q;
      fail_d    = fail_q;
      b0_d      = b0_q;
      b1_d      = b1_q;
      tmr_d     = tmr_done ? tmr_q : tmr_q - TW'(1);
      failure   = 1'b0;
      fail_tgt  = ST_RST_SEND;
      pkt_done  = 1'b0;

      case (state_q)
         ST_RST_SEND, ST_EN_SEND: begin
            if (!tx_req_q) begin
               tx_req_d  = 1'b1;
               tx_data_d = (state_q == ST_RST_SEND) ? 8'hFF : 8'hF4;
            end else if (tx_done) begin
               tx_req_d = 1'b0;
               tmr_d    = TMR_LOAD;
               state_d  = (state_q == ST_RST_SEND) ? ST_RST_ACK : ST_EN_ACK;
            end else if (tx_err) begin
               failure  = 1'b1;
               fail_tgt = state_q;
            end
         end
         // A resend request (0xFE) to the reset command lands in RST_SEND,
         // which is also where every other failure goes.
         ST_RST_ACK: begin
            if (rx_valid) begin
               if (rx_data == 8'hFA) begin
                  state_d = ST_RST_BAT;
                  tmr_d   = TMR_LOAD;
               end else
                  failure = 1'b1;
            end else if (tmr_done)
               failure = 1'b1;
         end
         ST_RST_BAT: begin
            if (rx_valid) begin
               if (rx_data == 8'hAA) begin
                  state_d = ST_RST_ID;
                  tmr_d   = TMR_LOAD;
               end else
                  failure = 1'b1;
            end else if (tmr_done)
               failure = 1'b1;
         end
         ST_RST_ID: begin
            if (rx_valid) begin
               if (rx_data == 8'h00)
                  state_d = ST_EN_SEND;
               else
                  failure = 1'b1;
            end else if (tmr_done)
               failure = 1'b1;
         end
         ST_EN_ACK: begin
            if (rx_valid) begin
               if (rx_data == 8'hFA) begin
                  state_d = ST_STREAM_B0;
                  retry_d = '0;
               end else begin
                  failure = 1'b1;
                  if (rx_data == 8'hFE)
                     fail_tgt = ST_EN_SEND;
               end
            end else if (tmr_done)
               failure = 1'b1;
         end
         ST_STREAM_B0: begin
            if (rx_valid && rx_data[3]) begin
               b0_d    = rx_data;
               tmr_d   = TMR_LOAD;
               state_d = ST_STREAM_B1;
            end
         end
         ST_STREAM_B1: begin
            if (rx_valid) begin
               b1_d    = rx_data;
               tmr_d   = TMR_LOAD;
               state_d = ST_STREAM_B2;
            end else if (tmr_done)
               state_d = ST_STREAM_B0;
         end
         ST_STREAM_B2: begin
            if (rx_valid) begin
               pkt_done = 1'b1;
               state_d  = ST_STREAM_B0;
            end else if (tmr_done)
               state_d = ST_STREAM_B0;
         end
         default: ;
      endcase

      if (failure) begin
         retry_d  = retry_inc[RW-1:0];
         tx_req_d = 1'b0;
         if (retry_inc >= RETRY_LIM) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
         end else
            state_d = fail_tgt;
      end

      // Dropping tx_req here guarantees a one-cycle gap before the new 0xFF.
      if (restart) begin
         state_d  = ST_RST_SEND;
         tx_req_d = 1'b0;
         retry_d  = '0;
         fail_d   = 1'b0;
      end

      ready_d = (state_d == ST_STREAM_B0) || (state_d == ST_STREAM_B1) ||
                (state_d == ST_STREAM_B2);
   end

   assign pkt_done_ok = pkt_done & ~restart;

   always_ff @(posedge iCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_RST_SEND;
         tx_req_q  <= 1'b0;
         tx_data_q <= 8'h00;
         retry_q   <= '0;
         tmr_q     <= '0;
         b0_q      <= 8'h00;
         b1_q      <= 8'h00;
         fail_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_req_q  <= tx_req_d;
         tx_data_q <= tx_data_d;
         retry_q   <= retry_d;
         tmr_q     <= tmr_d;
         b0_q      <= b0_d;
         b1_q      <= b1_d;
         fail_q    <= fail_d;
         ready_q   <= ready_d;
      end
   end

   mouse_ps2_regs #(
      .BUFFER_ADDR (BUFFER_ADDR),
      .STATUS_ADDR (STATUS_ADDR)
   ) u_regs (
      .clk_sys   (iCLK),
      .rst_b     (Reset_n),
      .rd_en     (wReadEnable),
      .wr_en     (wWriteEnable),
      .byte_en   (wByteEnable),
      .addr      (wAddress),
      .wr_data   (wWriteData),
      .pkt_done  (pkt_done_ok),
      .pkt_bytes ({rx_data, b1_q, b0_q}),
      .fail      (fail_q),
      .ready     (ready_q),
      .restart   (restart),
      .valid     (valid),
      .rd_hit    (rd_hit),
      .rd_val    (rd_val)
   );

   assign wReadData = rd_hit ? rd_val : 32'hzzzz_zzzz;
   assign tx_data   = tx_data_q;
   assign tx_req    = tx_req_q;
   assign oIRQ      = valid;
   assign oReady    = ready_q;
endmodule

// File: tb/tb_mouse_ps2_controller.sv
module tb_mouse_ps2_controller;
   localparam logic [31:0] BUF_A  = 32'hFF200110;
   localparam logic [31:0] STAT_A = 32'hFF200114;
   localparam int          TMO    = 40;

   logic        iCLK = 1'b0;
   logic        Reset_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_req;
   logic        tx_done = 1'b0;
   logic        tx_err = 1'b0;
   logic        wReadEnable = 1'b0;
   logic        wWriteEnable = 1'b0;
   logic [3:0]  wByteEnable = 4'h0;
   logic [31:0] wAddress = 32'h0;
   logic [31:0] wWriteData = 32'h0;
   logic [31:0] wReadData;
   logic        oIRQ;
   logic        oReady;

   mouse_ps2_controller #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(3)) dut (
      .iCLK(iCLK), .Reset_n(Reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done), .tx_err(tx_err),
      .wReadEnable(wReadEnable), .wWriteEnable(wWriteEnable),
      .wByteEnable(wByteEnable), .wAddress(wAddress), .wWriteData(wWriteData),
      .wReadData(wReadData), .oIRQ(oIRQ), .oReady(oReady)
   );

   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: packet assembly as a queue of pending bytes.
   logic [7:0]  m_seq;
   logic [31:0] m_pkt;
   logic        m_valid, m_overrun;
   logic [7:0]  m_part[$];

   typedef struct {
      logic [7:0]  b[4];
      int          n;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic wait_tx(input logic [7:0] exp, input string name);
      int k = 0;
      while (tx_req !== 1'b1 && k < 6 * TMO) begin
         @(negedge iCLK);
         k++;
      end
      check({name, " tx_req"}, 32'(tx_req), 32'd1);
      check({name, " tx_data"}, 32'(tx_data), 32'(exp));
      tx_done = 1'b1;
      @(negedge iCLK);
      tx_done = 1'b0;
      check({name, " tx_req drop"}, 32'(tx_req), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge iCLK);
      rx_valid = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      wAddress    = addr;
      wReadEnable = 1'b1;
      #1 data = wReadData;
      @(negedge iCLK);
      wReadEnable = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      wAddress     = addr;
      wWriteData   = data;
      wByteEnable  = be;
      wWriteEnable = 1'b1;
      @(negedge iCLK);
      wWriteEnable = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_part.size() == 0) begin
         if (b[3]) m_part.push_back(b);
      end else begin
         m_part.push_back(b);
         if (m_part.size() == 3) begin
            m_seq = m_seq + 8'd1;
            m_pkt = {m_seq, m_part[2], m_part[1], m_part[0]};
            if (m_valid) m_overrun = 1'b1;
            m_valid = 1'b1;
            m_part.delete();
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  b;

      vecs[0].b = '{8'h08, 8'h05, 8'hFB, 8'h00}; vecs[0].n = 3; vecs[0].exp = 32'h01FB0508;
      vecs[1].b = '{8'h00, 8'h09, 8'h10, 8'h20}; vecs[1].n = 4; vecs[1].exp = 32'h02201009;
      vecs[2].b = '{8'hF7, 8'h18, 8'hFF, 8'h01}; vecs[2].n = 4; vecs[2].exp = 32'h0301FF18;
      vecs[3].b = '{8'h0F, 8'h80, 8'h7F, 8'h00}; vecs[3].n = 3; vecs[3].exp = 32'h047F800F;

      // Reset state
      wAddress = STAT_A;
      #1;
      check("rst tx_req", 32'(tx_req), 32'd0);
      check("rst tx_data", 32'(tx_data), 32'h00);
      check("rst oIRQ", 32'(oIRQ), 32'd0);
      check("rst oReady", 32'(oReady), 32'd0);
      check("rst status", wReadData, 32'h0);
      @(negedge iCLK);
      @(negedge iCLK);
      Reset_n = 1'b1;

      // Init handshake
      wait_tx(8'hFF, "init FF");
      send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
      wait_tx(8'hF4, "init F4");
      send_byte(8'hFA);
      check("init oReady", 32'(oReady), 32'd1);
      bus_read(STAT_A, rd);
      check("init status", rd, 32'h2);

      // Packet table
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
         check($sformatf("vec%0d irq", i), 32'(oIRQ), 32'd1);
         bus_read(BUF_A, rd);
         check($sformatf("vec%0d pkt", i), rd, vecs[i].exp);
         check($sformatf("vec%0d irq clr", i), 32'(oIRQ), 32'd0);
      end

      // Ignored writes
      bus_write(STAT_A, 32'h2, 4'hF);
      bus_write(BUF_A, 32'h1, 4'hF);
      bus_write(STAT_A, 32'h1, 4'hE);
      idle(1);
      check("ignored write ready", 32'(oReady), 32'd1);

      // Overrun
      send_byte(8'h08); send_byte(8'h11); send_byte(8'h22);
      send_byte(8'h18); send_byte(8'h33); send_byte(8'h44);
      bus_read(STAT_A, rd);
      check("overrun status", rd, 32'hB);
      bus_read(STAT_A, rd);
      check("overrun cleared", rd, 32'h3);
      bus_read(BUF_A, rd);
      check("overrun pkt", rd, 32'h06443318);

      // Completion on the same edge as a clearing buffer read
      send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
      send_byte(8'h08); send_byte(8'h03);
      rx_data = 8'h04; rx_valid = 1'b1;
      wAddress = BUF_A; wReadEnable = 1'b1;
      #1 rd = wReadData;
      check("same-edge old pkt", rd, 32'h07020108);
      @(negedge iCLK);
      rx_valid = 1'b0; wReadEnable = 1'b0;
      check("same-edge irq", 32'(oIRQ), 32'd1);
      bus_read(STAT_A, rd);
      check("same-edge status", rd, 32'h3);
      bus_read(BUF_A, rd);
      check("same-edge new pkt", rd, 32'h08040308);

      // Inter-byte timeout discards partial packet
      send_byte(8'h08);
      idle(3 * TMO);
      send_byte(8'h01); send_byte(8'h09); send_byte(8'h02); send_byte(8'h03);
      bus_read(BUF_A, rd);
      check("timeout pkt", rd, 32'h09030209);

      // Retries exhausted
      bus_write(STAT_A, 32'h1, 4'h1);
      for (int i = 0; i < 3; i++) wait_tx(8'hFF, $sformatf("retry%0d", i));
      idle(3 * TMO);
      check("fail tx_req", 32'(tx_req), 32'd0);
      bus_read(STAT_A, rd);
      check("fail status", rd, 32'h4);

      // Restart, then restart again mid-transmission
      bus_write(STAT_A, 32'h1, 4'h1);
      begin
         int k = 0;
         while (tx_req !== 1'b1 && k < 10) begin @(negedge iCLK); k++; end
      end
      check("restart2 req up", 32'(tx_req), 32'd1);
      bus_write(STAT_A, 32'h1, 4'h1);
      check("restart2 gap", 32'(tx_req), 32'd0);
      idle(1);
      check("restart2 reissue", 32'(tx_req), 32'd1);
      wait_tx(8'hFF, "restart FF");
      bus_read(STAT_A, rd);
      check("restart status", rd, 32'h0);
      send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
      wait_tx(8'hF4, "en F4");
      send_byte(8'hFE);
      wait_tx(8'hF4, "en F4 resend");
      send_byte(8'hFA);
      check("resend ready", 32'(oReady), 32'd1);

      // Randomized stream against the queue model
      m_seq = 8'd9; m_pkt = 32'h09030209; m_valid = 1'b0; m_overrun = 1'b0;
      m_part.delete();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(3 * TMO);
            if (m_part.size() != 0) m_part.delete();
         end else
            idle($urandom_range(0, 4));
         b = 8'($urandom);
         send_byte(b);
         model_byte(b);
         check($sformatf("rnd%0d irq", i), 32'(oIRQ), 32'(m_valid));
         case ($urandom_range(0, 2))
            1: begin
               bus_read(BUF_A, rd);
               check($sformatf("rnd%0d pkt", i), rd, m_pkt);
               m_valid = 1'b0;
            end
            2: begin
               bus_read(STAT_A, rd);
               check($sformatf("rnd%0d status", i), rd, {28'b0, m_overrun, 1'b0, 1'b1, m_valid});
               m_overrun = 1'b0;
            end
            default: ;
         endcase
      end

      // Asynchronous reset mid-packet
      idle(3 * TMO);
      send_byte(8'h08); send_byte(8'h05); send_byte(8'h06);
      send_byte(8'h08); send_byte(8'h07);
      check("pre-reset irq", 32'(oIRQ), 32'd1);
      #2 Reset_n = 1'b0;
      wAddress = STAT_A;
      #1;
      check("async tx_req", 32'(tx_req), 32'd0);
      check("async tx_data", 32'(tx_data), 32'h00);
      check("async oIRQ", 32'(oIRQ), 32'd0);
      check("async oReady", 32'(oReady), 32'd0);
      check("async status", wReadData, 32'h0);
      wAddress = BUF_A;
      #1 check("async pkt", wReadData, 32'h0);
      @(negedge iCLK);
      Reset_n = 1'b1;
      @(negedge iCLK);
      check("post-reset tx_req", 32'(tx_req), 32'd1);
      check("post-reset tx_data", 32'(tx_data), 32'hFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/mouse_ps2_controller.md
Name: mouse_ps2_controller

Overview:
Sequences a PS/2 mouse over a byte-level PS/2 transceiver and exposes assembled movement packets on the IO bus.
- Init: sends reset (0xFF) and checks ACK/BAT/ID, then sends enable-streaming (0xF4) and checks its ACK.
- Stream: assembles 3-byte packets with sync checking and inter-byte timeout.
- Bus: publishes packets and status through memory-mapped registers and raises a level interrupt.
Sits between the PS/2 byte transceiver and the processor IO bus, alongside the keyboard/mouse peripherals.

Parameters:
BUFFER_ADDR, 32'hFF200110, bus address of packet register (read).
STATUS_ADDR, 32'hFF200114, bus address of status register (read) and control register (write).
TIMEOUT_CYCLES, 1000000, iCLK cycles allowed for any expected response or next packet byte.
MAX_RETRY, 3, failed init attempts before entering FAIL.

Ports:
iCLK  in  1  system clock, all logic on posedge
Reset_n  in  1  reset; asynchronous assert, active-low
rx_data  in  8  byte received from transceiver
rx_valid  in  1  one-cycle pulse, rx_data valid
tx_data  out  8  command byte to transmit
tx_req  out  1  transmit request, held until tx_done or tx_err
tx_done  in  1  one-cycle pulse, byte sent
tx_err  in  1  one-cycle pulse, transmission failed
wReadEnable  in  1  bus read strobe
wWriteEnable  in  1  bus write strobe
wByteEnable  in  4  bus byte enables
wAddress  in  32  bus address
wWriteData  in  32  bus write data
wReadData  out  32  bus read data, 32'hzzzzzzzz when not addressed
oIRQ  out  1  level interrupt, equals packet-valid flag
oReady  out  1  1 while in stream states

Behaviour:
Reset values (Reset_n low, asynchronous):
- state=RST_SEND, tx_req=0, tx_data=8'h00.
- Retry counter and timeout counter = 0.
- Packet register = 0, seq = 0, valid/overrun/fail = 0.
- oIRQ=0, oReady=0.
- First command is issued on the first clock after release.

Send states (RST_SEND, EN_SEND):
- Drive tx_data (0xFF or 0xF4) and assert tx_req.
- tx_done: drop tx_req the same edge and go to the matching ACK state.
- tx_err: counts as a failure.

Wait states (RST_ACK expects 0xFA, RST_BAT expects 0xAA, RST_ID expects 0x00, EN_ACK expects 0xFA):
- Timeout counter clears on state entry and on every rx_valid.
- Expected byte: advance RST_ACK->RST_BAT->RST_ID->EN_SEND; EN_ACK->STREAM_B0.
- 0xFE received in RST_ACK or EN_ACK: resend the same command; counts as a failure.
- Any other byte, or timeout reaching TIMEOUT_CYCLES: failure, go to RST_SEND.

Failure rule:
- Retry counter increments on each failure.
- When the counter reaches MAX_RETRY: go to FAIL (fail=1, tx_req=0, stays until restart).
- Retry counter clears on entering STREAM_B0 from EN_ACK.

Stream states:
- STREAM_B0: accept a byte only if bit3=1; otherwise discard and stay.
- STREAM_B1, STREAM_B2: store the next byte. Timeout with no byte returns to STREAM_B0 and discards the partial packet.
- Byte in STREAM_B2 completes a packet: packet register = {seq+1, b2, b1, b0}; seq increments mod 256; valid=1.
- Completion while valid=1 also sets overrun=1.
- oReady=1 in STREAM_B0/B1/B2 only.

Bus:
- wReadData is combinational. BUFFER_ADDR returns the packet register. STATUS_ADDR returns {28'b0, overrun, fail, oReady, valid}. Any other address returns Z.
- Each posedge with wReadEnable and address==BUFFER_ADDR clears valid.
- Each posedge with wReadEnable and address==STATUS_ADDR clears overrun.
- Packet completion on the same edge as a clearing read: the new packet wins (valid stays 1, overrun not set).
- Write to STATUS_ADDR with wByteEnable[0]=1 and wWriteData[0]=1: restart. Go to RST_SEND, clear the retry counter, valid, overrun and fail; packet register and seq are kept.
- Restart in any state, including mid-transmission: tx_req drops for one cycle before the new request.
- Writes to other addresses, or with wWriteData[0]=0, are ignored.
- oIRQ = valid.

Test Plan:
1. Release reset; tx_done each send; respond FA, AA, 00, then FA -> tx_data sequence FF then F4; oReady=1; status reads 0x2.
2. After init, bytes 08, 05, FB -> oIRQ=1; read BUFFER_ADDR returns 0x01FB0508; oIRQ=0 the next cycle.
3. Bytes 00, 09, 10, 20 -> 00 discarded; packet 0x..201009 with seq incremented; no timeout.
4. No responses after each tx_done, MAX_RETRY=3 -> 0xFF sent exactly 3 times; status fail bit=1, tx_req=0; write 0x1 to STATUS_ADDR -> FF sent again, fail=0.
5. Two complete packets without reads -> status overrun=1, buffer holds second packet (seq=2); status read clears overrun.
6. Respond FE to F4 -> F4 retransmitted; then FA -> stream. Assert Reset_n low mid-packet -> all outputs at reset values asynchronously.
